sram_7x15_ctrl: RTL

//  Initiator/controller for the sram_7x15 register file (2 async read ports, 1 sync write port).

---
 rtl/sram_7x15_ctrl_if.sv | 28 ++
 rtl/sram_7x15_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sram_7x15_ctrl_if.sv
// Request/response handshake bundle between a CPU-side initiator and sram_7x15_ctrl.
// The master issues read-pair or write requests and consumes the responses.
interface sram_7x15_ctrl_if #(
  parameter int DW = 15,
  parameter int AW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_a1;
  logic [AW-1:0] req_a2;
  logic [DW-1:0] req_wd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_d1;
  logic [DW-1:0] rsp_d2;
  logic          rsp_err;

  modport master (
    output req_valid, req_wr, req_a1, req_a2, req_wd, rsp_ready,
    input  req_ready, rsp_valid, rsp_d1, rsp_d2, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_a1, req_a2, req_wd, rsp_ready,
    output req_ready, rsp_valid, rsp_d1, rsp_d2, rsp_err
  );
endinterface

// File: rtl/sram_7x15_ctrl.sv
// Controller for the 7x15 register file: one write or one dual read per request,
// address range checking, and a held response until the consumer takes it.
module sram_7x15_ctrl #(
  parameter int DW    = 15,
  parameter int AW    = 3,
  parameter int DEPTH = 7
) (
  input  logic          clk,
  input  logic          rst,
  sram_7x15_ctrl_if.slave bus,
  output logic [AW-1:0] RA1,
  output logic [AW-1:0] RA2,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] WD,
  output logic          WE,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  state_t        state_q;
  state_t        next_state;
  logic          wr_go;
  logic          rd_go;
  logic          err_go;
  logic          a1_ok;
  logic          a2_ok;
  logic [DW-1:0] d1_q;
  logic [DW-1:0] d2_q;
  logic          err_q;

  assign a1_ok = {1'b0, bus.req_a1} < LIMIT;
  assign a2_ok = {1'b0, bus.req_a2} < LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Illegal requests skip the SRAM entirely and go straight to the response.
  always_comb begin
    next_state    = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    wr_go         = 1'b0;
    rd_go         = 1'b0;
    err_go        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_wr) begin
            if (a1_ok) begin
              wr_go      = 1'b1;
              next_state = WRITE;
            end else begin
              err_go     = 1'b1;
              next_state = RESP;
            end
          end else begin
            if (a1_ok && a2_ok) begin
              rd_go      = 1'b1;
              next_state = READ;
            end else begin
              err_go     = 1'b1;
              next_state = RESP;
            end
          end
        end
      end
      WRITE: next_state = RESP;
      READ:  next_state = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // WE follows wr_go by one edge, so it is high only for the single WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RA1   <= '0;
      RA2   <= '0;
      WA    <= '0;
      WD    <= '0;
      WE    <= 1'b0;
      d1_q  <= '0;
      d2_q  <= '0;
      err_q <= 1'b0;
    end else begin
      WE <= wr_go;
      if (wr_go) begin
        WA    <= bus.req_a1;
        WD    <= bus.req_wd;
        d1_q  <= '0;
        d2_q  <= '0;
        err_q <= 1'b0;
      end
      if (rd_go) begin
        RA1   <= bus.req_a1;
        RA2   <= bus.req_a2;
        err_q <= 1'b0;
      end
      if (err_go) begin
        d1_q  <= '0;
        d2_q  <= '0;
        err_q <= 1'b1;
      end
      if (state_q == READ) begin
        d1_q <= RD1;
        d2_q <= RD2;
      end
    end
  end

  assign bus.rsp_d1  = d1_q;
  assign bus.rsp_d2  = d2_q;
  assign bus.rsp_err = err_q;

endmodule
